ras_predecode: RTL and testbench

RAS_PREDECODE -- requirements
Module: ras_predecode

---
 rtl/ras_predecode_if.sv | 23 ++
 rtl/ras_predecode.sv | 114 +++++++++++
 tb/tb_ras_predecode.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_predecode_if.sv
// rtl/ras_predecode_if.sv - fetch-slot and RAS request bundle for ras_predecode
interface ras_predecode_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] pc_i;
    logic [31:0]      instr_i;
    logic             kill_i;
    logic             push_o;
    logic             pop_o;
    logic [WIDTH-1:0] ret_addr_o;

    modport master (
        output valid_i, pc_i, instr_i, kill_i,
        input  ready_o, push_o, pop_o, ret_addr_o
    );

    modport slave (
        input  valid_i, pc_i, instr_i, kill_i,
        output ready_o, push_o, pop_o, ret_addr_o
    );
endinterface

// File: rtl/ras_predecode.sv
// rtl/ras_predecode.sv - call/return predecoder issuing RAS push/pop requests
// Optional RVC call/return decode enabled by defining RAS_COMPRESSED_EN.
module ras_predecode #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_ni,
    ras_predecode_if.slave  bus
);
    typedef enum logic {IDLE, PUSH_PEND} state_t;

    state_t           r_state;
    logic             r_push;
    logic             r_pop;
    logic [WIDTH-1:0] r_ret_addr;
    logic [WIDTH-1:0] r_pend_addr;

    logic             w_push;
    logic             w_pop;
    logic             w_co;
    logic [WIDTH-1:0] w_ret;
    logic             w_accept;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic             w_rd_link;
    logic             w_rs1_link;
    logic             w_unused;

    assign w_rd       = bus.instr_i[11:7];
    assign w_rs1      = bus.instr_i[19:15];
    assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_unused   = ^bus.instr_i[31:20];

    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_co   = 1'b0;
        w_ret  = bus.pc_i + WIDTH'(4);
        if (bus.instr_i[1:0] == 2'b11) begin
            if (bus.instr_i[6:0] == 7'b1101111) begin
                w_push = w_rd_link;
            end else if (bus.instr_i[6:0] == 7'b1100111 && bus.instr_i[14:12] == 3'b000) begin
                w_pop  = !w_rd_link && w_rs1_link;
                w_push = w_rd_link && (!w_rs1_link || (w_rd == w_rs1));
                w_co   = w_rd_link && w_rs1_link && (w_rd != w_rs1);
            end
        end
`ifdef RAS_COMPRESSED_EN
        else begin
            // Compressed forms: rd/rs1 share bits [11:7]; C.JALR links x1 implicitly.
            w_ret = bus.pc_i + WIDTH'(2);
            if (bus.instr_i[1:0] == 2'b01 && bus.instr_i[15:13] == 3'b001) begin
                w_push = 1'b1;
            end else if (bus.instr_i[1:0] == 2'b10 && bus.instr_i[6:2] == 5'd0 &&
                         w_rd != 5'd0) begin
                if (bus.instr_i[15:12] == 4'b1000) begin
                    w_pop = w_rd_link;
                end else if (bus.instr_i[15:12] == 4'b1001) begin
                    w_co   = (w_rd == 5'd5);
                    w_push = (w_rd != 5'd5);
                end
            end
        end
`endif
    end

    assign w_accept = bus.valid_i && (r_state == IDLE) && !bus.kill_i;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_ret_addr  <= '0;
            r_pend_addr <= '0;
        end else begin
            r_push <= 1'b0;
            r_pop  <= 1'b0;
            if (bus.kill_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            if (w_co) begin
                                r_pop       <= 1'b1;
                                r_pend_addr <= w_ret;
                                r_state     <= PUSH_PEND;
                            end else begin
                                r_push <= w_push;
                                r_pop  <= w_pop;
                                if (w_push) begin
                                    r_ret_addr <= w_ret;
                                end
                            end
                        end
                    end
                    PUSH_PEND: begin
                        r_push     <= 1'b1;
                        r_ret_addr <= r_pend_addr;
                        r_state    <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ready_o    = (r_state == IDLE);
    assign bus.push_o     = r_push;
    assign bus.pop_o      = r_pop;
    assign bus.ret_addr_o = r_ret_addr;
endmodule

// File: tb/tb_ras_predecode.sv
// tb/tb_ras_predecode.sv - directed self-checking bench for ras_predecode
module tb_ras_predecode;
    logic clk;
    logic rst_ni;
    int   vectors;
    int   miscompares;

    ras_predecode_if #(.WIDTH(32)) bus ();

    ras_predecode #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] JAL_X1      = 32'h0000_00EF;
    localparam logic [31:0] JAL_X5      = 32'h0000_02EF;
    localparam logic [31:0] RET_X1      = 32'h0000_8067;
    localparam logic [31:0] ADD_X1      = 32'h0010_80B3;
    localparam logic [31:0] JALR_X1_X5  = 32'h0002_80E7;
    localparam logic [31:0] JALR_X1_X1  = 32'h0000_80E7;
    localparam logic [31:0] JALR_X1_X6  = 32'h0003_00E7;
    localparam logic [31:0] C_JALR_X5   = 32'h0000_9282;
    localparam logic [31:0] C_JR_X1     = 32'h0000_8082;

    // Presents one slot at a falling edge; returns at the next falling edge
    // with valid_i low, so outputs then show the cycle after acceptance.
    task automatic present(input logic [31:0] pc, input logic [31:0] instr, input logic kill);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.pc_i    = pc;
        bus.instr_i = instr;
        bus.kill_i  = kill;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.instr_i = 32'h0;
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.push_o !== 1'b0 || bus.pop_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_req push=%b pop=%b required 0 0", bus.push_o, bus.pop_o);
        end
        vectors++;
        if (bus.ret_addr_o !== 32'h0 || bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state ret=%h ready=%b required 00000000 1", bus.ret_addr_o, bus.ready_o);
        end
    endtask

    task automatic test_jal();
        present(32'h0000_1000, JAL_X1, 1'b0);
        vectors++;
        if (bus.push_o !== 1'b1 || bus.pop_o !== 1'b0 || bus.ret_addr_o !== 32'h0000_1004) begin
            miscompares++;
            $display("FAIL jal_x1 push=%b pop=%b ret=%h required 1 0 00001004",
                     bus.push_o, bus.pop_o, bus.ret_addr_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL jal_one_shot push=%b required 0", bus.push_o);
        end
    endtask

    task automatic test_jalr_variants();
        present(32'h0000_1100, RET_X1, 1'b0);
        vectors++;
        if (bus.pop_o !== 1'b1 || bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ret_pop pop=%b push=%b required 1 0", bus.pop_o, bus.push_o);
        end
        present(32'h0000_1200, ADD_X1, 1'b0);
        vectors++;
        if (bus.pop_o !== 1'b0 || bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL add_none pop=%b push=%b required 0 0", bus.pop_o, bus.push_o);
        end
        present(32'h0000_1300, JALR_X1_X1, 1'b0);
        vectors++;
        if (bus.push_o !== 1'b1 || bus.pop_o !== 1'b0 || bus.ret_addr_o !== 32'h0000_1304) begin
            miscompares++;
            $display("FAIL jalr_same_link push=%b pop=%b ret=%h required 1 0 00001304",
                     bus.push_o, bus.pop_o, bus.ret_addr_o);
        end
        present(32'h0000_1400, JALR_X1_X6, 1'b0);
        vectors++;
        if (bus.push_o !== 1'b1 || bus.pop_o !== 1'b0 || bus.ret_addr_o !== 32'h0000_1404) begin
            miscompares++;
            $display("FAIL jalr_nonlink_rs1 push=%b pop=%b ret=%h required 1 0 00001404",
                     bus.push_o, bus.pop_o, bus.ret_addr_o);
        end
    endtask

    task automatic test_valid_low();
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.pc_i    = 32'h0000_5000;
        bus.instr_i = JAL_X1;
        @(negedge clk);
        vectors++;
        if (bus.push_o !== 1'b0 || bus.pop_o !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_low push=%b pop=%b required 0 0", bus.push_o, bus.pop_o);
        end
        bus.instr_i = 32'h0;
    endtask

    task automatic test_coroutine();
        present(32'h0000_2000, JALR_X1_X5, 1'b0);
        vectors++;
        if (bus.pop_o !== 1'b1 || bus.push_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL co_pop pop=%b push=%b ready=%b required 1 0 0",
                     bus.pop_o, bus.push_o, bus.ready_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.push_o !== 1'b1 || bus.pop_o !== 1'b0 || bus.ret_addr_o !== 32'h0000_2004) begin
            miscompares++;
            $display("FAIL co_push push=%b pop=%b ret=%h required 1 0 00002004",
                     bus.push_o, bus.pop_o, bus.ret_addr_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.ready_o !== 1'b1 || bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL co_done ready=%b push=%b required 1 0", bus.ready_o, bus.push_o);
        end
    endtask

    task automatic test_kill();
        present(32'h0000_6000, JAL_X1, 1'b1);
        vectors++;
        if (bus.push_o !== 1'b0 || bus.pop_o !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_slot push=%b pop=%b required 0 0", bus.push_o, bus.pop_o);
        end
        present(32'h0000_7000, JALR_X1_X5, 1'b0);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        vectors++;
        if (bus.push_o !== 1'b0 || bus.pop_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_pend push=%b pop=%b ready=%b required 0 0 1",
                     bus.push_o, bus.pop_o, bus.ready_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_no_late_push push=%b required 0", bus.push_o);
        end
    endtask

    task automatic test_wrap();
        present(32'hFFFF_FFFC, JAL_X5, 1'b0);
        vectors++;
        if (bus.push_o !== 1'b1 || bus.ret_addr_o !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL wrap push=%b ret=%h required 1 00000000", bus.push_o, bus.ret_addr_o);
        end
    endtask

    task automatic test_reset_mid();
        int pushes;
        present(32'h0000_8000, JALR_X1_X5, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (bus.push_o !== 1'b0 || bus.pop_o !== 1'b0 || bus.ret_addr_o !== 32'h0 ||
            bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_async push=%b pop=%b ret=%h ready=%b required 0 0 00000000 1",
                     bus.push_o, bus.pop_o, bus.ret_addr_o, bus.ready_o);
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        pushes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.push_o === 1'b1) pushes++;
        end
        vectors++;
        if (pushes !== 0) begin
            miscompares++;
            $display("FAIL reset_no_push pushes=%0d required 0", pushes);
        end
    endtask

    task automatic test_compressed();
        present(32'h0000_3000, C_JALR_X5, 1'b0);
`ifdef RAS_COMPRESSED_EN
        vectors++;
        if (bus.pop_o !== 1'b1 || bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL c_jalr_pop pop=%b push=%b required 1 0", bus.pop_o, bus.push_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.push_o !== 1'b1 || bus.ret_addr_o !== 32'h0000_3002) begin
            miscompares++;
            $display("FAIL c_jalr_push push=%b ret=%h required 1 00003002", bus.push_o, bus.ret_addr_o);
        end
        present(32'h0000_3100, C_JR_X1, 1'b0);
        vectors++;
        if (bus.pop_o !== 1'b1 || bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL c_jr_pop pop=%b push=%b required 1 0", bus.pop_o, bus.push_o);
        end
`else
        vectors++;
        if (bus.pop_o !== 1'b0 || bus.push_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL c_jalr_none pop=%b push=%b ready=%b required 0 0 1",
                     bus.pop_o, bus.push_o, bus.ready_o);
        end
        present(32'h0000_3100, C_JR_X1, 1'b0);
        vectors++;
        if (bus.pop_o !== 1'b0 || bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL c_jr_none pop=%b push=%b required 0 0", bus.pop_o, bus.push_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.kill_i  = 1'b0;
        bus.pc_i    = 32'h0000_4000;
        bus.instr_i = JAL_X1;
        @(negedge clk);
        vectors++;
        if (bus.push_o !== 1'b1 || bus.ret_addr_o !== 32'h0000_4004) begin
            miscompares++;
            $display("FAIL b2b_first push=%b ret=%h required 1 00004004", bus.push_o, bus.ret_addr_o);
        end
        bus.pc_i    = 32'h0000_4010;
        bus.instr_i = RET_X1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        vectors++;
        if (bus.pop_o !== 1'b1 || bus.push_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second pop=%b push=%b required 1 0", bus.pop_o, bus.push_o);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni      = 1'b0;
        bus.valid_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.pc_i    = 32'h0;
        bus.instr_i = 32'h0;
        #12;
        test_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        test_jal();
        test_jalr_variants();
        test_valid_low();
        test_coroutine();
        test_kill();
        test_wrap();
        test_reset_mid();
        test_compressed();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
